ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- Pipeline register directly upstream of the logic unit (AND/OR/XOR), on the decode-to-execute boundary.
- Captures decoded instructions and resolves data forwarding from the EX/MEM and MEM/WB stages.
- Selects register or immediate for operand 2.
- Presents a registered control code plus two 16-bit operands to the ALU, with valid/ready flow control, flush and a stall counter.

Parameters:
- DATA_W, 16, operand/result width
- CTRL_W, 3, ALU control code width
- REG_ADDR_W, 3, register address width (8 registers; R0 reads as zero)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous kill of the held instruction
- in_valid  input  1  decode offers an instruction
- in_ready  output  1  stage accepts this cycle
- in_control  input  CTRL_W  ALU operation code
- in_rs1_addr, in_rs2_addr  input  REG_ADDR_W  source register addresses
- in_rs1_data, in_rs2_data  input  DATA_W  register-file read data
- in_imm  input  DATA_W  immediate, already extended
- in_use_imm  input  1  operand2 = immediate
- in_rd_addr  input  REG_ADDR_W  destination register
- in_rd_we  input  1  destination write enable
- exm_we, exm_rd, exm_data  input  1/REG_ADDR_W/DATA_W  EX/MEM forwarding source
- wb_we, wb_rd, wb_data  input  1/REG_ADDR_W/DATA_W  MEM/WB forwarding source
- out_valid  output  1  ALU inputs valid
- out_ready  input  1  downstream consumes
- out_control  output  CTRL_W  to ALU control
- out_operand1, out_operand2  output  DATA_W  to ALU operands
- out_rd_addr  output  REG_ADDR_W  passed through
- out_rd_we  output  1  passed through
- stall_count  output  16  saturating count of stalled cycles

Behaviour:
- Reset (rst_n low, async): out_valid=0; out_control, operands, out_rd_addr=0; out_rd_we=0; stall_count=0. Held stored rs addresses and the use_imm flag are cleared.
- in_ready = !out_valid || out_ready. This is combinational, so in_ready=1 immediately after reset.
- Capture: when in_valid && in_ready && !flush, all out_* registers load on the next edge and out_valid=1. Latency is 1 cycle.
- If in_ready and no capture occurs, out_valid=0 next cycle.
- Forwarding priority per source operand, resolved at capture:
  - address 0 → 0x0000 regardless of sources;
  - else exm_we && exm_rd==addr → exm_data;
  - else wb_we && wb_rd==addr → wb_data;
  - else register-file data.
- Operand 2: in_use_imm=1 → in_imm, and forwarding for rs2 is ignored.
- Hold refresh: while out_valid && !out_ready, each non-immediate operand with stored address ≠0 re-applies the same priority against the current exm/wb buses.
  - A matching write overwrites the held operand.
  - With no match, the held value is kept.
  - Operands never revert to register-file data while held.
- Held outputs other than refreshed operands are stable while out_valid && !out_ready.
- flush: next edge out_valid=0. Flush beats capture in the same cycle, so the offered instruction is dropped.
  - Data registers may keep stale values; consumers use out_valid.
- Simultaneous out_ready and in_valid with a full stage: the old instruction is consumed and the new one captured on the same edge (full throughput).
- Control codes pass through unchanged. The stage does not decode or reject codes; the ALU defines unknown-code behaviour.
- stall_count increments on each cycle with out_valid && !out_ready, saturating at 0xFFFF. It is cleared only by reset.
- Reset mid-stall clears everything asynchronously; no partial capture survives.

Decomposition:
- Package alu_pkg holds:
  - DATA_W, CTRL_W, REG_ADDR_W;
  - control constants ALU_AND=3'b011, ALU_OR=3'b100, ALU_XOR=3'b101;
  - enum fwd_sel_e {FWD_ZERO, FWD_EXM, FWD_WB, FWD_RF}.
- Sub-module operand_forward_mux: combinational priority select, instantiated twice. It also serves as the hold-refresh selector, with stored value replacing RF data.

Test Plan:
- Reset then single capture: rst_n pulse low, then in_valid=1, control=ALU_XOR, rs1 data 0x00F0, rs2 data 0x0FF0 (addrs 1, 2, no forwarding), out_ready=1 → next cycle out_valid=1, out_operand1=0x00F0, out_operand2=0x0FF0, out_control=3'b101; stall_count=0.
- Forward priority: rs1=3 with exm_we=1, exm_rd=3, exm_data=0xAAAA and wb_we=1, wb_rd=3, wb_data=0x5555 → out_operand1=0xAAAA. Repeat with exm_we=0 → 0x5555. Repeat with rs1=0 → 0x0000.
- Immediate: in_use_imm=1, imm=0x1234, rs2 matching exm_rd → out_operand2=0x1234.
- Stall and refresh: out_ready=0 for 4 cycles with a held rs1=5; in cycle 2 wb_we=1, wb_rd=5, wb_data=0xBEEF → out_operand1 becomes 0xBEEF and stays; in_ready=0 throughout; stall_count=4; on release the next instruction is captured in the same cycle.
- Flush vs capture: flush=1 with in_valid=1, in_ready=1 → out_valid=0 next cycle; the instruction is not presented later.
- Saturation: force 70000 stalled cycles → stall_count=0xFFFF; async rst_n low mid-stall → all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, ALU control codes and forwarding-source encoding for the
// decode-to-execute operand stage.
package alu_pkg;

  localparam int DATA_W     = 16;
  localparam int CTRL_W     = 3;
  localparam int REG_ADDR_W = 3;

  localparam logic [CTRL_W-1:0] ALU_AND = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b100;
  localparam logic [CTRL_W-1:0] ALU_XOR = 3'b101;

  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_EXM,
    FWD_WB,
    FWD_RF
  } fwd_sel_e;

endpackage

// File: rtl/operand_forward_mux.sv
// Priority select for one source operand: R0 -> zero, then EX/MEM, then MEM/WB,
// then base_data (register-file data at capture, the held value while stalled).
module operand_forward_mux
  import alu_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  exm_we,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]     exm_data,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic [DATA_W-1:0]     base_data,
  output logic [DATA_W-1:0]     data
);

  fwd_sel_e sel;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel = FWD_RF;
    if (addr == '0)                    sel = FWD_ZERO;
    else if (exm_we && exm_rd == addr) sel = FWD_EXM;
    else if (wb_we && wb_rd == addr)   sel = FWD_WB;
  end

  always_comb begin
    data = base_data;
    case (sel)
      FWD_ZERO: data = '0;
      FWD_EXM:  data = exm_data;
      FWD_WB:   data = wb_data;
      default:  data = base_data;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Decode-to-execute pipeline register: resolves forwarding, selects the immediate,
// and holds ALU inputs under valid/ready flow control with flush and stall counting.
module ex_operand_stage
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_control,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [DATA_W-1:0]     in_rs1_data,
  input  logic [DATA_W-1:0]     in_rs2_data,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  in_use_imm,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_rd_we,
  input  logic                  exm_we,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]     exm_data,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_control,
  output logic [DATA_W-1:0]     out_operand1,
  output logic [DATA_W-1:0]     out_operand2,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_rd_we,
  output logic [15:0]           stall_count
);

  logic [REG_ADDR_W-1:0] rs1_q, rs2_q;
  logic                  use_imm_q;
  logic                  hold, capture;
  logic [REG_ADDR_W-1:0] sel_rs1, sel_rs2;
  logic [DATA_W-1:0]     base1, base2, fwd1, fwd2;

  assign in_ready = !out_valid || out_ready;
  assign hold     = out_valid && !out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // The same muxes serve capture (fresh addresses, RF data) and hold refresh
  // (stored addresses, held operand), so a stalled operand never reverts to RF data.
  assign sel_rs1 = hold ? rs1_q : in_rs1_addr;
  assign sel_rs2 = hold ? rs2_q : in_rs2_addr;
  assign base1   = hold ? out_operand1 : in_rs1_data;
  assign base2   = hold ? out_operand2 : in_rs2_data;

  operand_forward_mux u_fwd1 (
    .addr(sel_rs1), .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .base_data(base1), .data(fwd1)
  );

  operand_forward_mux u_fwd2 (
    .addr(sel_rs2), .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .base_data(base2), .data(fwd2)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_control  <= '0;
      out_operand1 <= '0;
      out_operand2 <= '0;
      out_rd_addr  <= '0;
      out_rd_we    <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      use_imm_q    <= 1'b0;
      stall_count  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid    <= 1'b1;
        out_control  <= in_control;
        out_operand1 <= fwd1;
        out_operand2 <= in_use_imm ? in_imm : fwd2;
        out_rd_addr  <= in_rd_addr;
        out_rd_we    <= in_rd_we;
        rs1_q        <= in_rs1_addr;
        rs2_q        <= in_rs2_addr;
        use_imm_q    <= in_use_imm;
      end else if (in_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_operand1 <= fwd1;
        if (!use_imm_q) out_operand2 <= fwd2;
      end

      if (hold && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table for capture/forwarding,
// hand sequences for stall refresh, flush, saturation and async reset.
module tb_ex_operand_stage;
  import alu_pkg::*;

  logic                  clk, rst_n, flush, in_valid, in_ready;
  logic [CTRL_W-1:0]     in_control;
  logic [REG_ADDR_W-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [DATA_W-1:0]     in_rs1_data, in_rs2_data, in_imm;
  logic                  in_use_imm, in_rd_we;
  logic                  exm_we, wb_we;
  logic [REG_ADDR_W-1:0] exm_rd, wb_rd;
  logic [DATA_W-1:0]     exm_data, wb_data;
  logic                  out_valid, out_ready, out_rd_we;
  logic [CTRL_W-1:0]     out_control;
  logic [DATA_W-1:0]     out_operand1, out_operand2;
  logic [REG_ADDR_W-1:0] out_rd_addr;
  logic [15:0]           stall_count;

  int errors = 0;
  int checks = 0;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_control(out_control),
    .out_operand1(out_operand1), .out_operand2(out_operand2),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  ctrl;
    logic [2:0]  rs1, rs2;
    logic [15:0] d1, d2, imm;
    logic        use_imm;
    logic        exm_we;
    logic [2:0]  exm_rd;
    logic [15:0] exm_data;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  rd;
    logic        rd_we;
    logic [15:0] e1, e2;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive(input vec_t v);
    in_control  = v.ctrl;
    in_rs1_addr = v.rs1;
    in_rs2_addr = v.rs2;
    in_rs1_data = v.d1;
    in_rs2_data = v.d2;
    in_imm      = v.imm;
    in_use_imm  = v.use_imm;
    exm_we      = v.exm_we;
    exm_rd      = v.exm_rd;
    exm_data    = v.exm_data;
    wb_we       = v.wb_we;
    wb_rd       = v.wb_rd;
    wb_data     = v.wb_data;
    in_rd_addr  = v.rd;
    in_rd_we    = v.rd_we;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ctrl"}, 32'(out_control), 32'd0);
    check({tag, "_op1"}, 32'(out_operand1), 32'd0);
    check({tag, "_op2"}, 32'(out_operand2), 32'd0);
    check({tag, "_rd"}, 32'(out_rd_addr), 32'd0);
    check({tag, "_rdwe"}, 32'(out_rd_we), 32'd0);
    check({tag, "_stall"}, 32'(stall_count), 32'd0);
  endtask

  initial begin
    vec_t v;
    //         ctrl     rs1 rs2 d1        d2        imm       ui  xwe xrd xdata     wwe wrd wdata     rd  we  e1        e2
    vecs[0] = '{ALU_XOR, 1, 2, 16'h00F0, 16'h0FF0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 3, 1, 16'h00F0, 16'h0FF0};
    vecs[1] = '{ALU_AND, 3, 4, 16'h1111, 16'h4444, 16'h0000, 0, 1, 3, 16'hAAAA, 1, 3, 16'h5555, 5, 1, 16'hAAAA, 16'h4444};
    vecs[2] = '{ALU_OR,  3, 4, 16'h1111, 16'h4444, 16'h0000, 0, 0, 3, 16'hAAAA, 1, 3, 16'h5555, 6, 0, 16'h5555, 16'h4444};
    vecs[3] = '{ALU_XOR, 0, 2, 16'h7777, 16'h2222, 16'h0000, 0, 1, 0, 16'hAAAA, 1, 0, 16'h5555, 7, 1, 16'h0000, 16'h2222};
    vecs[4] = '{ALU_AND, 1, 6, 16'h0101, 16'h6666, 16'h1234, 1, 1, 6, 16'hDEAD, 0, 0, 16'h0000, 2, 1, 16'h0101, 16'h1234};
    vecs[5] = '{ALU_OR,  7, 5, 16'h7070, 16'h0000, 16'h0000, 0, 1, 4, 16'hDEAD, 1, 5, 16'hCAFE, 1, 0, 16'h7070, 16'hCAFE};
    vecs[6] = '{3'b111,  2, 0, 16'h2020, 16'h9999, 16'h0000, 0, 1, 0, 16'hDEAD, 0, 0, 16'h0000, 4, 1, 16'h2020, 16'h0000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    #3;
    check_all_zero("reset");
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    // Table: capture with forwarding/immediate, full throughput with out_ready=1.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid = 1'b1;
      @(posedge clk) #1;
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_ctrl", i), 32'(out_control), 32'(vecs[i].ctrl));
      check($sformatf("v%0d_op1", i), 32'(out_operand1), 32'(vecs[i].e1));
      check($sformatf("v%0d_op2", i), 32'(out_operand2), 32'(vecs[i].e2));
      check($sformatf("v%0d_rd", i), 32'(out_rd_addr), 32'(vecs[i].rd));
      check($sformatf("v%0d_rdwe", i), 32'(out_rd_we), 32'(vecs[i].rd_we));
    end
    check("no_stall_yet", 32'(stall_count), 32'd0);

    // Stall with hold refresh of rs1=5 from the WB bus in the second stalled cycle.
    @(negedge clk);
    v = '{ALU_AND, 5, 2, 16'h1111, 16'h2222, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 3, 1, 0, 0};
    drive(v);
    @(posedge clk) #1;
    check("stall_cap_op1", 32'(out_operand1), 32'h1111);
    @(negedge clk);
    out_ready = 1'b0;
    v = '{ALU_OR, 1, 3, 16'h9999, 16'h3333, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 6, 0, 0, 0};
    drive(v);
    for (int c = 1; c <= 4; c++) begin
      wb_we   = (c == 2);
      wb_rd   = 3'd5;
      wb_data = 16'hBEEF;
      #1 check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk) #1;
      check($sformatf("stall%0d_op1", c), 32'(out_operand1), (c >= 2) ? 32'hBEEF : 32'h1111);
      check($sformatf("stall%0d_op2", c), 32'(out_operand2), 32'h2222);
      check($sformatf("stall%0d_ctrl", c), 32'(out_control), 32'(ALU_AND));
      @(negedge clk);
    end
    wb_we = 1'b0;
    check("stall_count4", 32'(stall_count), 32'd4);
    out_ready = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk) #1;
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_op1", 32'(out_operand1), 32'h9999);
    check("release_ctrl", 32'(out_control), 32'(ALU_OR));
    check("release_count", 32'(stall_count), 32'd4);

    // Flush beats capture; the dropped instruction never appears.
    @(negedge clk);
    v = '{ALU_XOR, 1, 2, 16'h3333, 16'h4444, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 7, 1, 0, 0};
    drive(v);
    flush = 1'b1;
    @(posedge clk) #1;
    check("flush_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk) #1;
    check("flush_after_valid", 32'(out_valid), 32'd0);

    // Saturation over a long stall, then asynchronous reset mid-stall.
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk) #1;
    check("sat_cap_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1 check("sat_count", 32'(stall_count), 32'hFFFF);
    check("sat_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
